// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants for the sync generator and the pixel path.
// The defaults describe 640x480 @ 60 Hz with a 25 MHz pixel clock.
package vga_timing_pkg;

  // Counter widths shared by the generator and its consumers
  localparam int CNT_W  = 10;
  localparam int FCNT_W = 8;

  // Horizontal timing in pixel clocks
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  // Vertical timing in lines
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Pixel path latency: ROM read plus registered RGB
  localparam int VGA_PIPE_DLY = 2;

  // Full period of one axis: active + front porch + sync + back porch
  function automatic int span_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

  // First count at which sync is asserted
  function automatic int sync_first(input int act, input int fp);
    return act + fp;
  endfunction

  // Last count at which sync is asserted (inclusive)
  function automatic int sync_last(input int act, input int fp, input int sy);
    return act + fp + sy - 1;
  endfunction

  // Derived default values, usable by the pixel path without recomputation
  localparam int VGA_H_TOTAL      = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL      = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
  localparam int VGA_H_SYNC_START = sync_first(VGA_H_ACTIVE, VGA_H_FP);
  localparam int VGA_H_SYNC_END   = sync_last(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC);
  localparam int VGA_V_SYNC_START = sync_first(VGA_V_ACTIVE, VGA_V_FP);
  localparam int VGA_V_SYNC_END   = sync_last(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC);

  // Sync pair as it travels through the delay line (both active-low)
  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_pair_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA sync generator: raster position, active-area
// qualifier, delayed syncs and frame/line strobes.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0]  hc;
  logic [CNT_W-1:0]  vc;
  logic              valid;
  logic              hsync;
  logic              vsync;
  logic              frame_tick;
  logic              line_tick;
  logic [FCNT_W-1:0] frame_cnt;

  // Generator side drives everything
  modport master (
    output hc, vc, valid, hsync, vsync, frame_tick, line_tick, frame_cnt
  );

  // Pixel path / display side observes everything
  modport slave (
    input hc, vc, valid, hsync, vsync, frame_tick, line_tick, frame_cnt
  );

endinterface

// File: rtl/sync_delay.sv
// Fixed-depth shift register that lines the sync outputs up with the pixel
// path latency. Every stage restarts at 1 (inactive for active-low syncs) so
// no stale pulse can leave the line after a reset. STAGES = 0 is a wire.
module sync_delay #(
  parameter int DATA_W = 2,
  parameter int STAGES = 2
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_bypass
      // Clock and reset have no job without storage
      logic unused_bypass;
      assign unused_bypass = clk_25m ^ rst;
      assign dout = din;
    end else begin : g_shift
      logic [DATA_W-1:0] stage_q [STAGES];

      // Shift one stage per pixel clock; reset refills with inactive level
      always_ff @(posedge clk_25m) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '1;
          end
        end else begin
          stage_q[0] <= din;
          for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign dout = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator. Produces the pixel/line counters, the
// active-area qualifier, frame/line strobes and a frame counter, plus
// hsync/vsync delayed by PIPE_DLY clocks to match the pixel path.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int PIPE_DLY = VGA_PIPE_DLY
) (
  input  logic           clk_25m,
  input  logic           rst,
  vga_sync_gen_if.master vif
);

  localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  // All decode thresholds pre-sized to the counter width
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_LIM  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LIM  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  // Modulo increment: the terminal count goes straight to zero, so no
  // out-of-range value is ever loaded into the counter.
  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] last);
    return (cnt == last) ? '0 : cnt + 1'b1;
  endfunction

  logic [CNT_W-1:0]  hc_q;
  logic [CNT_W-1:0]  vc_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              h_wrap;
  logic              frame_hit;
  sync_pair_t        sync_p0;
  sync_pair_t        sync_out;

  // Decode terminal counts, last active pixel and undelayed syncs
  always_comb begin
    h_wrap        = 1'b0;
    frame_hit     = 1'b0;
    sync_p0.hsync = 1'b1;
    sync_p0.vsync = 1'b1;
    h_wrap        = (hc_q == H_LAST);
    frame_hit     = (hc_q == H_ACT_LAST) && (vc_q == V_ACT_LAST);
    sync_p0.hsync = !((hc_q >= HS_FIRST) && (hc_q <= HS_LAST));
    sync_p0.vsync = !((vc_q >= VS_FIRST) && (vc_q <= VS_LAST));
  end

  // Raster counters; reset wins over any wrap in the same cycle
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= wrap_inc(hc_q, H_LAST);
      if (h_wrap) begin
        vc_q <= wrap_inc(vc_q, V_LAST);
      end
    end
  end

  // Completed-frame counter, bumped the cycle after the last active pixel
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_hit) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  // ---- sync pipeline: sync_p0 -> PIPE_DLY stages -> sync_out ----
  sync_delay #(
    .DATA_W ($bits(sync_pair_t)),
    .STAGES (PIPE_DLY)
  ) u_sync_delay (
    .clk_25m (clk_25m),
    .rst     (rst),
    .din     (sync_p0),
    .dout    (sync_out)
  );

  assign vif.hc         = hc_q;
  assign vif.vc         = vc_q;
  assign vif.valid      = !rst && (hc_q < H_ACT_LIM) && (vc_q < V_ACT_LIM);
  assign vif.line_tick  = h_wrap;
  assign vif.frame_tick = frame_hit;
  assign vif.frame_cnt  = frame_cnt_q;
  assign vif.hsync      = sync_out.hsync;
  assign vif.vsync      = sync_out.vsync;

endmodule
